// File: rtl/bus_pkg.sv
// Shared types and helpers for the memory-bus fabric: transaction state
// enum, default error read data and the packed base/limit slot accessor.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } bus_state_e;

    localparam logic [31:0] BUS_ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          BUS_MAX_SLAVES        = 16;

    // Extract 32-bit slot i from a packed address table.
    function automatic logic [31:0] bus_slot(
        input logic [32*BUS_MAX_SLAVES-1:0] vec,
        input int                           i
    );
        return vec[32*i +: 32];
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority address decoder; lowest matching slot wins.
// Ports: mem_addr in, hit out (any slot matched), idx out (winning slot).
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int                          NUM_SLAVES  = 8,
    parameter logic [32*NUM_SLAVES-1:0]    SLAVE_BASE  = '0,
    parameter logic [32*NUM_SLAVES-1:0]    SLAVE_LIMIT = '0,
    parameter int                          IDX_W       = 3
) (
    input  logic [31:0]      mem_addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    localparam logic [32*BUS_MAX_SLAVES-1:0] BASE_X  =
        (32*BUS_MAX_SLAVES)'(SLAVE_BASE);
    localparam logic [32*BUS_MAX_SLAVES-1:0] LIMIT_X =
        (32*BUS_MAX_SLAVES)'(SLAVE_LIMIT);

    // Scan from the top so the lowest index is written last and wins.
    // A slot with base == limit can never match.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem_addr >= bus_slot(BASE_X, i)) &&
                (mem_addr <  bus_slot(LIMIT_X, i))) begin
                hit = 1'b1;
                idx = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// picorv32 native memory port to NUM_SLAVES slave interconnect with
// registered decode, unmapped/timeout errors and a sticky error irq.
// Ports: CPU side mem_valid/addr/wstrb -> mem_ready/rdata; slave side
// slave_sel -> slave_ready/rdata; error side err_clr -> bus_err/err_irq/
// err_addr. Define BUS_TIMEOUT_EN to build the slave-stall timeout.
module mem_bus_fabric
    import bus_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 8,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = '0,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_LIMIT    = '0,
    parameter int                       TIMEOUT_CYCLES = 256,
    parameter logic [31:0]              ERR_RDATA      = BUS_ERR_RDATA_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mem_valid,
    input  logic [31:0]                mem_addr,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic [NUM_SLAVES-1:0]      slave_sel,
    input  logic [NUM_SLAVES-1:0]      slave_ready,
    input  logic [32*NUM_SLAVES-1:0]   slave_rdata,
    input  logic                       err_clr,
    output logic                       bus_err,
    output logic                       err_irq,
    output logic [31:0]                err_addr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_e            state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_irq_q, err_irq_d;
    logic [31:0]           err_addr_q, err_addr_d;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic                  cur_ready;
    logic [31:0]           cur_rdata;
    logic                  timeout;
    logic                  wstrb_unused;

    // Write strobes go straight to the slaves outside this block.
    assign wstrb_unused = ^mem_wstrb;

    bus_addr_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .SLAVE_BASE  (SLAVE_BASE),
        .SLAVE_LIMIT (SLAVE_LIMIT),
        .IDX_W       (IDX_W)
    ) u_decode (
        .mem_addr (mem_addr),
        .hit      (dec_hit),
        .idx      (dec_idx)
    );

    always_comb begin
        cur_ready = 1'b0;
        cur_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                cur_ready = slave_ready[i];
                cur_rdata = slave_rdata[32*i +: 32];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts completed stall cycles, so it equals
    // TIMEOUT_CYCLES-1 during the last permitted ACTIVE cycle.
    assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_ACTIVE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        mem_ready = 1'b0;
        mem_rdata = '0;
        bus_err   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (dec_hit) begin
                        state_d = ST_ACTIVE;
                        idx_d   = dec_idx;
                        sel_d   = NUM_SLAVES'(1) << dec_idx;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ACTIVE: begin
                mem_ready = mem_valid & cur_ready;
                mem_rdata = cur_rdata;
                // Ready in the final permitted cycle beats the timeout.
                if (!mem_valid || cur_ready) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                    sel_d   = '0;
                end
            end
            ST_ERROR: begin
                mem_ready = mem_valid;
                mem_rdata = ERR_RDATA;
                bus_err   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // A new error wins over a simultaneous clear.
    always_comb begin
        err_irq_d  = (state_q == ST_ERROR) | (err_irq_q & ~err_clr);
        err_addr_d = (state_q == ST_ERROR) ? mem_addr : err_addr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            idx_q      <= '0;
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            err_irq_q  <= err_irq_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign slave_sel = sel_q;
    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed self-checking bench for mem_bus_fabric: decode, priority,
// unmapped errors, timeout, irq set/clear collision and async reset.
module tb_mem_bus_fabric;

    localparam int NS = 4;
    localparam logic [32*NS-1:0] BASE =
        {32'h0, 32'h0002_0000, 32'h0, 32'h0};
    localparam logic [32*NS-1:0] LIMIT =
        {32'h0, 32'h0002_2000, 32'h0001_3000, 32'h0000_0010};
    localparam logic [31:0] EDATA = 32'hDEAD_BEEF;

    logic              clk;
    logic              reset_n;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [NS-1:0]     slave_sel;
    logic [NS-1:0]     slave_ready;
    logic [32*NS-1:0]  slave_rdata;
    logic              err_clr;
    logic              bus_err;
    logic              err_irq;
    logic [31:0]       err_addr;

    int errors = 0;
    int checks = 0;

    assign slave_rdata = {32'hC0DE_0003, 32'hC0DE_0002,
                          32'hC0DE_0001, 32'hC0DE_0000};

    mem_bus_fabric #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     (BASE),
        .SLAVE_LIMIT    (LIMIT),
        .TIMEOUT_CYCLES (4),
        .ERR_RDATA      (EDATA)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .slave_sel   (slave_sel),
        .slave_ready (slave_ready),
        .slave_rdata (slave_rdata),
        .err_clr     (err_clr),
        .bus_err     (bus_err),
        .err_irq     (err_irq),
        .err_addr    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n     = 1'b0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_wstrb   = '0;
        slave_ready = '0;
        err_clr     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err, err_irq} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0",
                     {slave_sel, mem_ready, bus_err, err_irq});
        end
        checks++;
        if ({mem_rdata, err_addr} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {mem_rdata, err_addr});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 0",
                     {slave_sel, mem_ready, bus_err});
        end
    endtask

    task automatic test_zero_wait();
        slave_ready = 4'hF;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0002_0004;
        #1;
        checks++;
        if ({slave_sel, mem_ready} !== 5'b0) begin
            errors++;
            $display("FAIL zw_cycle1: got %b want 0",
                     {slave_sel, mem_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err} !== 6'b0100_10) begin
            errors++;
            $display("FAIL zw_cycle2: got %b want 010010",
                     {slave_sel, mem_ready, bus_err});
        end
        checks++;
        if (mem_rdata !== 32'hC0DE_0002) begin
            errors++;
            $display("FAIL zw_rdata: got %h want c0de0002", mem_rdata);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        checks++;
        if ({slave_sel, mem_ready} !== 5'b0) begin
            errors++;
            $display("FAIL zw_release: got %b want 0",
                     {slave_sel, mem_ready});
        end
    endtask

    task automatic test_priority();
        logic [31:0] addrs [4] = '{32'h8, 32'h10, 32'h0001_2FFC,
                                   32'h0002_1FFC};
        logic [3:0]  sels  [4] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100};
        logic [31:0] datas [4] = '{32'hC0DE_0000, 32'hC0DE_0001,
                                   32'hC0DE_0001, 32'hC0DE_0002};
        slave_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_valid = 1'b1;
            mem_addr  = addrs[k];
            @(negedge clk);
            #1;
            checks++;
            if ({slave_sel, mem_ready, bus_err} !== {sels[k], 2'b10}) begin
                errors++;
                $display("FAIL prio_sel[%0d]: got %b want %b", k,
                         {slave_sel, mem_ready, bus_err},
                         {sels[k], 2'b10});
            end
            checks++;
            if (mem_rdata !== datas[k]) begin
                errors++;
                $display("FAIL prio_rdata[%0d]: got %h want %h", k,
                         mem_rdata, datas[k]);
            end
            @(negedge clk);
            mem_valid = 1'b0;
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [2] = '{32'h9000_0000, 32'h0002_2000};
        slave_ready = 4'hF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_valid = 1'b1;
            mem_addr  = addrs[k];
            #1;
            checks++;
            if ({mem_ready, bus_err} !== 2'b00) begin
                errors++;
                $display("FAIL um_cycle1[%0d]: got %b want 00", k,
                         {mem_ready, bus_err});
            end
            @(negedge clk);
            #1;
            checks++;
            if ({slave_sel, mem_ready, bus_err} !== 6'b0000_11) begin
                errors++;
                $display("FAIL um_cycle2[%0d]: got %b want 000011", k,
                         {slave_sel, mem_ready, bus_err});
            end
            checks++;
            if (mem_rdata !== EDATA) begin
                errors++;
                $display("FAIL um_rdata[%0d]: got %h want %h", k,
                         mem_rdata, EDATA);
            end
            @(negedge clk);
            mem_valid = 1'b0;
            #1;
            checks++;
            if ({err_addr, err_irq, bus_err} !== {addrs[k], 2'b10}) begin
                errors++;
                $display("FAIL um_capture[%0d]: got %h want %h", k,
                         {err_addr, err_irq, bus_err},
                         {addrs[k], 2'b10});
            end
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        checks++;
        if (err_irq !== 1'b0) begin
            errors++;
            $display("FAIL um_clear: got %b want 0", err_irq);
        end
    endtask

    task automatic test_timeout();
        slave_ready = 4'h0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0002_0004;
`ifdef BUS_TIMEOUT_EN
        for (int a = 1; a <= 4; a++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({slave_sel, mem_ready, bus_err} !== 6'b0100_00) begin
                errors++;
                $display("FAIL to_stall[%0d]: got %b want 010000", a,
                         {slave_sel, mem_ready, bus_err});
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err} !== 6'b0000_11) begin
            errors++;
            $display("FAIL to_error: got %b want 000011",
                     {slave_sel, mem_ready, bus_err});
        end
        checks++;
        if (mem_rdata !== EDATA) begin
            errors++;
            $display("FAIL to_rdata: got %h want %h", mem_rdata, EDATA);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        checks++;
        if ({err_addr, err_irq} !== {32'h0002_0004, 1'b1}) begin
            errors++;
            $display("FAIL to_capture: got %h want %h",
                     {err_addr, err_irq}, {32'h0002_0004, 1'b1});
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        mem_valid = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({slave_sel, mem_ready, bus_err} !== 6'b0100_00) begin
                errors++;
                $display("FAIL to_late_stall[%0d]: got %b want 010000",
                         a, {slave_sel, mem_ready, bus_err});
            end
        end
`else
        for (int a = 1; a <= 6; a++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({slave_sel, mem_ready, bus_err} !== 6'b0100_00) begin
                errors++;
                $display("FAIL nt_stall[%0d]: got %b want 010000", a,
                         {slave_sel, mem_ready, bus_err});
            end
        end
`endif
        @(negedge clk);
        slave_ready = 4'b0100;
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err} !== 6'b0100_10) begin
            errors++;
            $display("FAIL late_ready: got %b want 010010",
                     {slave_sel, mem_ready, bus_err});
        end
        checks++;
        if (mem_rdata !== 32'hC0DE_0002) begin
            errors++;
            $display("FAIL late_rdata: got %h want c0de0002", mem_rdata);
        end
        @(negedge clk);
        mem_valid   = 1'b0;
        slave_ready = 4'h0;
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err, err_irq} !== 7'b0) begin
            errors++;
            $display("FAIL late_done: got %b want 0",
                     {slave_sel, mem_ready, bus_err, err_irq});
        end
    endtask

    task automatic test_err_clr_collision();
        slave_ready = 4'hF;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h9000_0000;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h9000_0040;
        @(negedge clk);
        err_clr = 1'b1;
        #1;
        checks++;
        if ({bus_err, err_irq} !== 2'b11) begin
            errors++;
            $display("FAIL coll_pre: got %b want 11", {bus_err, err_irq});
        end
        @(negedge clk);
        err_clr   = 1'b0;
        mem_valid = 1'b0;
        #1;
        checks++;
        if ({err_irq, err_addr} !== {1'b1, 32'h9000_0040}) begin
            errors++;
            $display("FAIL coll_set_wins: got %h want %h",
                     {err_irq, err_addr}, {1'b1, 32'h9000_0040});
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        slave_ready = 4'h0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0002_0004;
        @(negedge clk);
        #1;
        checks++;
        if (slave_sel !== 4'b0100) begin
            errors++;
            $display("FAIL rm_active: got %b want 0100", slave_sel);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err, err_irq} !== 7'b0) begin
            errors++;
            $display("FAIL rm_immediate: got %b want 0",
                     {slave_sel, mem_ready, bus_err, err_irq});
        end
        checks++;
        if (mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rm_rdata: got %h want 0", mem_rdata);
        end
        @(negedge clk);
        mem_valid   = 1'b0;
        reset_n     = 1'b1;
        slave_ready = 4'hF;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h8;
        @(negedge clk);
        #1;
        checks++;
        if ({slave_sel, mem_ready, bus_err} !== 6'b0001_10) begin
            errors++;
            $display("FAIL rm_next: got %b want 000110",
                     {slave_sel, mem_ready, bus_err});
        end
        checks++;
        if (mem_rdata !== 32'hC0DE_0000) begin
            errors++;
            $display("FAIL rm_next_rdata: got %h want c0de0000", mem_rdata);
        end
        @(negedge clk);
        mem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_priority();
        test_unmapped();
        test_timeout();
        test_err_clr_collision();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_fabric.md
# mem_bus_fabric

Parametrised memory-bus interconnect between the picorv32 native memory port and NUM_SLAVES memory-mapped slaves. Replaces the hand-written per-slave select/ready/rdata logic in the SoC top with a table-driven, registered decoder. Adds a transaction FSM, unmapped-address errors, a slave-stall timeout and an error-capture interrupt source.

## Interface

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16)
- SLAVE_BASE, all zero, 32*NUM_SLAVES bits; slave i inclusive base address at [32*i+31:32*i]
- SLAVE_LIMIT, all zero, 32*NUM_SLAVES bits; slave i exclusive end address, same packing; base==limit disables the slot
- TIMEOUT_CYCLES, 256, maximum ACTIVE cycles before a stalled access is aborted (≥2)
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on any error completion

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock (pll_clk domain)
- reset_n  in  1  asynchronous active-low reset
- mem_valid  in  1  CPU request valid
- mem_addr  in  32  CPU byte address
- mem_wstrb  in  4  CPU write strobes (passed through unmodified, not used here)
- mem_ready  out  1  transaction complete to CPU
- mem_rdata  out  32  read data to CPU
- slave_sel  out  NUM_SLAVES  one-hot slave select
- slave_ready  in  NUM_SLAVES  per-slave ready
- slave_rdata  in  32*NUM_SLAVES  per-slave read data, slave i at [32*i+31:32*i]
- err_clr  in  1  clears sticky error flag
- bus_err  out  1  one-cycle pulse on every error completion
- err_irq  out  1  sticky error flag, for a CPU irq line
- err_addr  out  32  address of most recent errored access

## Operation

- Decode: hit[i] = (mem_addr >= base_i) && (mem_addr < limit_i). Lowest index wins on overlap (boot ROM shadowing flash occupies slot 0).
- FSM states: IDLE, ACTIVE, ERROR.
- IDLE: on mem_valid with a hit, register winning index, clear timeout counter, go ACTIVE. On mem_valid with no hit, go ERROR. Otherwise stay.
- ACTIVE: slave_sel[idx]=1. mem_ready = mem_valid & slave_ready[idx]; mem_rdata = slave_rdata[idx]. On ready, go IDLE. If mem_valid drops, go IDLE without error. Otherwise increment counter.
- ERROR: slave_sel all zero; mem_ready=mem_valid; mem_rdata=ERR_RDATA; bus_err=1; err_addr latched with mem_addr; err_irq set. Go IDLE.
- err_irq cleared by err_clr; a simultaneous set wins over clear.
- Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

## Timing

- Reset values: state IDLE, slave_sel 0, mem_ready 0, mem_rdata 0, bus_err 0, err_irq 0, err_addr 0, counter 0.
- slave_sel is registered: asserted the cycle after mem_valid is seen in IDLE. It deasserts on the edge following mem_ready.
- Zero-wait slave: mem_ready is asserted in the 2nd cycle of mem_valid.
- Unmapped access: mem_ready and bus_err are asserted in the 2nd cycle of mem_valid.
- Timeout: if slave_ready is still low in the TIMEOUT_CYCLES-th ACTIVE cycle, the next cycle is ERROR. slave_ready in that final cycle wins over the timeout.
- mem_ready and mem_rdata outside ACTIVE/ERROR: 0.
- A new transaction is accepted only from IDLE, so back-to-back accesses need at least one IDLE cycle.
- Asserting reset_n low mid-transaction: all outputs go to their reset values immediately, with no bus_err.

## Configuration

- BUS_TIMEOUT_EN defined: the timeout counter and the ACTIVE→ERROR transition are built.
- BUS_TIMEOUT_EN undefined: no counter is built. ACTIVE waits for ready indefinitely. Unmapped-address errors remain.

## Structure

- Shared package bus_pkg holds:
  - the state enum (IDLE/ACTIVE/ERROR)
  - BUS_ERR_RDATA_DEFAULT
  - a localparam function for the packed base/limit slice
- Sub-module bus_addr_decode: purely combinational priority decoder (mem_addr, SLAVE_BASE/LIMIT → hit, index).
- The FSM, counter, data mux and error registers stay in mem_bus_fabric.

## Test plan

- Slot 2 = [0x0002_0000, 0x0002_2000), zero-wait; read 0x0002_0004 → slave_sel=0b100 on cycle 2, mem_ready on cycle 2, rdata = slave 2 data.
- Slot 0 = [0,0x10), slot 1 = [0,0x13000); read 0x8 → slot 0 selected; read 0x10 → slot 1 selected.
- Read 0x9000_0000 (no map) → mem_ready and bus_err on cycle 2, rdata 0xDEAD_BEEF, err_addr 0x9000_0000, err_irq=1 until err_clr.
- TIMEOUT_CYCLES=4, slave holds ready low → ERROR after 4 ACTIVE cycles, sel drops, rdata 0xDEAD_BEEF. Repeat with ready in the 4th cycle → normal completion, no bus_err.
- err_clr pulsed in the same cycle as a new error → err_irq stays 1.
- reset_n low during ACTIVE with a stalled slave → sel, mem_ready and bus_err are 0 immediately. The next access completes normally.
